// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential front end for the 32-bit combinational ALU.
// Takes R-type commands over valid/ready, decodes funct to ALUop and drives
// registered ALU inputs. It captures Y/Less/Overflow one cycle later and
// returns one response per command over a second valid/ready handshake.
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [5:0]       cmd_funct,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_less,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovf,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic       accept;
    logic       legal;
    logic [3:0] dec_op;
    logic       dec_arith, dec_slt;
    // Op class of the command in flight; selects which ALU outputs are meaningful.
    logic       is_arith, is_slt;

    // funct -> ALUop decode plus op class; anything not listed is illegal
    always_comb begin
        legal     = 1'b1;
        dec_op    = 4'b0000;
        dec_arith = 1'b0;
        dec_slt   = 1'b0;
        case (cmd_funct)
            6'b100100: dec_op = 4'b0000;                     // AND
            6'b100101: dec_op = 4'b0001;                     // OR
            6'b100000: begin dec_op = 4'b0010; dec_arith = 1'b1; end // ADD
            6'b100010: begin dec_op = 4'b0110; dec_arith = 1'b1; end // SUB
            6'b101010: begin dec_op = 4'b0111; dec_slt   = 1'b1; end // SLT
            6'b100111: dec_op = 4'b1000;                     // NOR
            default:   legal  = 1'b0;
        endcase
    end

    assign accept = cmd_valid && (state == IDLE);

    // Next-state and handshake outputs; ready/valid depend on state only
    always_comb begin
        state_nxt = state;
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        case (state)
            IDLE:    if (cmd_valid) state_nxt = legal ? EXEC : RESP;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ALU operand/op registers and op class; only a legal accept updates them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= 4'b0000;
            is_arith <= 1'b0;
            is_slt   <= 1'b0;
        end else if (accept && legal) begin
            alu_a    <= cmd_a;
            alu_b    <= cmd_b;
            alu_op   <= dec_op;
            is_arith <= dec_arith;
            is_slt   <= dec_slt;
        end
    end

    // Response capture. Less/Overflow are X for ops that do not define them,
    // so they are only ever selected for SLT / ADD-SUB respectively.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept && !legal) begin
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b1;
        end else if (state == EXEC) begin
            rsp_result <= is_slt ? alu_less : alu_y;
            rsp_ovf    <= is_arith ? alu_overflow : 1'b0;
            rsp_err    <= 1'b0;
        end
    end

    // Completed-response counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      op_count <= '0;
        else if (state == RESP && rsp_ready)          op_count <= op_count + 1'b1;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, table vectors, hand-written
// multi-cycle sequences and randomized commands against a reference model.
// The counter is narrowed to 8 bits so wraparound is reachable quickly.
module tb_alu_issue_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
    logic [5:0]       cmd_funct = '0;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_y, alu_less;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_ovf, rsp_err;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    logic [3:0] last_op = 4'b0000;

    alu_issue_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_funct(cmd_funct),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_less(alu_less), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; Less/Overflow are X for ops that do not define them
    always_comb begin
        alu_y        = '0;
        alu_less     = 'x;
        alu_overflow = 1'bx;
        case (alu_op)
            4'b0000: alu_y = alu_a & alu_b;
            4'b0001: alu_y = alu_a | alu_b;
            4'b0010: begin
                alu_y = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            4'b0110: begin
                alu_y = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            4'b0111: begin
                alu_y    = alu_a - alu_b;
                alu_less = {31'b0, ($signed(alu_a) < $signed(alu_b))};
            end
            4'b1000: alu_y = ~(alu_a | alu_b);
            default: alu_y = '0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: architectural result from signed integer arithmetic
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                             output logic [31:0] r, output logic o, output logic e,
                             output logic [3:0] op);
        longint s;
        r = '0; o = 1'b0; e = 1'b0; op = last_op;
        case (f)
            6'b100100: begin r = a & b;    op = 4'b0000; end
            6'b100101: begin r = a | b;    op = 4'b0001; end
            6'b100111: begin r = ~(a | b); op = 4'b1000; end
            6'b100000: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); op = 4'b0010;
            end
            6'b100010: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); op = 4'b0110;
            end
            6'b101010: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; op = 4'b0111; end
            default:   e = 1'b1;
        endcase
    endtask

    // One full command: issue, measure latency, hold for 'hold' cycles of
    // backpressure, handshake. Checks everything against the model.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                           input int hold, output logic [31:0] r_o, output logic o_o,
                           output logic e_o, output logic [3:0] op_o);
        logic [31:0] r; logic o, e; logic [3:0] op;
        int lat;
        ref_model(a, b, f, r, o, e, op);
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_funct = f; cmd_valid = 1'b1; rsp_ready = 1'b0;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin @(negedge clk); lat++; end
        check("latency", lat, e ? 1 : 2);
        check("alu_op", alu_op, op);
        check("result", rsp_result, r);
        check("ovf", rsp_ovf, o);
        check("err", rsp_err, e);
        r_o = rsp_result; o_o = rsp_ovf; e_o = rsp_err; op_o = alu_op;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, r);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (CMAX + 1);
        last_op = op;
        check("post_valid", rsp_valid, 0);
        check("op_count", op_count, exp_cnt);
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic [5:0]  f;
        logic [31:0] r;
        logic        o, e;
        logic [3:0]  op;
    } vec_t;

    vec_t vecs[8];
    logic [5:0] legal_f[6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b100111};
    logic [31:0] corner[6] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h12345678};

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] r, a, b, held; logic o, e; logic [3:0] op; logic [5:0] f;

        vecs[0] = '{32'h5, 32'h3, 6'b100000, 32'h8, 1'b0, 1'b0, 4'b0010};
        vecs[1] = '{32'h80000000, 32'h1, 6'b100010, 32'h7FFFFFFF, 1'b1, 1'b0, 4'b0110};
        vecs[2] = '{32'h0, 32'h0, 6'b100111, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b1000};
        vecs[3] = '{32'hFFFFFFFF, 32'h1, 6'b101010, 32'h1, 1'b0, 1'b0, 4'b0111};
        vecs[4] = '{32'h1, 32'hFFFFFFFF, 6'b101010, 32'h0, 1'b0, 1'b0, 4'b0111};
        vecs[5] = '{32'h0, 32'h0, 6'b000000, 32'h0, 1'b0, 1'b1, 4'b0111};
        vecs[6] = '{32'hF0F0F0F0, 32'hFF00FF00, 6'b100100, 32'hF000F000, 1'b0, 1'b0, 4'b0000};
        vecs[7] = '{32'h7FFFFFFF, 32'h1, 6'b100000, 32'h80000000, 1'b1, 1'b0, 4'b0010};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_result", rsp_result, 0);
        check("rst_err", rsp_err, 0);
        check("rst_op_count", op_count, 0);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].a, vecs[i].b, vecs[i].f, 0, r, o, e, op);
            check("tbl_result", r, vecs[i].r);
            check("tbl_ovf", o, vecs[i].o);
            check("tbl_err", e, vecs[i].e);
            check("tbl_op", op, vecs[i].op);
        end

        // Backpressure with a second command waiting
        @(negedge clk);
        cmd_a = 32'h1; cmd_b = 32'h2; cmd_funct = 6'b100000; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_a = 32'hF0; cmd_b = 32'h0F; cmd_funct = 6'b100101;
        @(negedge clk);
        check("bp_valid", rsp_valid, 1);
        held = rsp_result;
        check("bp_first", held, 32'h3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result", rsp_result, held);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_alu_a", alu_a, 32'h1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (CMAX + 1);
        check("bp_idle_ready", cmd_ready, 1);
        check("bp_count", op_count, exp_cnt);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_accepted", alu_a, 32'hF0);
        check("bp_op", alu_op, 4'b0001);
        check("bp_busy", cmd_ready, 0);
        @(negedge clk);
        check("bp2_result", rsp_result, 32'hFF);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (CMAX + 1);
        last_op = 4'b0001;
        check("bp2_count", op_count, exp_cnt);

        // rsp_ready while idle is ignored
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_ready_count", op_count, exp_cnt);

        // Reset during EXEC
        @(negedge clk);
        cmd_a = 32'h9; cmd_b = 32'h9; cmd_funct = 6'b100000; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_count", op_count, 0);
        check("mid_rst_op", alu_op, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        last_op = 4'b0000;
        check("post_rst_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_rsp", rsp_valid, 0);
        end

        // Randomized commands against the model
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 5)];
            run_cmd(a, b, f, $urandom_range(0, 3), r, o, e, op);
        end

        // Counter wrap
        while (exp_cnt != CMAX) run_cmd(32'h0, 32'h0, 6'b111111, 0, r, o, e, op);
        check("wrap_max", op_count, CMAX);
        run_cmd(32'h2, 32'h3, 6'b100101, 0, r, o, e, op);
        check("wrap_zero", op_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
